// File: rtl/core_pkg.sv
// Shared core definitions: funct3 size/sign codes, memory-stage FSM states
// and UART register offsets.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] UART_DATA_OFS = 32'h0000_0000;
    localparam logic [31:0] UART_STAT_OFS = 32'h0000_0004;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BRAM_RD,
        S_BRAM_WR,
        S_TX_WAIT,
        S_RX_WAIT,
        S_RESP
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } acc_size_t;

    // Unknown encodings fall back to word access.
    function automatic acc_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-enable generation, store lane replication and
// load extraction/extension for byte/half/word accesses.
module load_store_align
    import core_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rword;
        case (f3_size(i_funct3))
            SZ_B: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_BU) ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_H: begin
                o_be    = 4'b0011 << {i_offset[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_funct3 == F3_HU) ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: one load/store/fetch per transaction against BRAM or
// the memory-mapped UART. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
    import core_pkg::*;
#(
    parameter int unsigned  BRAM_AW   = 15,
    parameter int unsigned  RD_LAT    = 2,
    parameter logic [31:0]  UART_BASE = 32'hFFFF_0000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req,
    input  logic               we,
    input  logic [2:0]         funct3,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic               bram_en,
    output logic [3:0]         bram_we,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [31:0]        bram_wdata,
    input  logic [31:0]        bram_rdata,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               rx_ready
);

    localparam logic [31:0] DATA_ADDR = UART_BASE + UART_DATA_OFS;
    localparam logic [31:0] STAT_ADDR = UART_BASE + UART_STAT_OFS;
    localparam logic [2:0]  LAT       = 3'(RD_LAT);

    mem_state_t           r_state, w_next;
    logic [BRAM_AW+1:0]   r_addr;
    logic [31:0]          r_wdata, r_rdata;
    logic [2:0]           r_funct3, r_cnt;
    logic [31:0]          w_addr_al, w_rword, w_rext, w_wrep;
    logic [3:0]           w_be;
    logic [1:0]           w_off;
    logic                 w_is_data, w_is_stat, w_is_bram, w_trap;

    // Low address bits below the access size are dropped up front.
    always_comb begin
        case (f3_size(funct3))
            SZ_H:    w_addr_al = {addr[31:1], 1'b0};
            SZ_W:    w_addr_al = {addr[31:2], 2'b00};
            default: w_addr_al = addr;
        endcase
        w_is_data = (w_addr_al[31:2] == DATA_ADDR[31:2]);
        w_is_stat = (w_addr_al[31:2] == STAT_ADDR[31:2]);
        w_is_bram = (w_addr_al[31:BRAM_AW+2] == '0);
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_err;
    assign w_trap = (w_addr_al != addr);
    always_ff @(posedge clk) begin
        if (!rstn)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && req)
            r_err <= w_trap;
    end
    assign err = (r_state == S_RESP) && r_err;
`else
    assign w_trap = 1'b0;
    assign err    = 1'b0;
`endif

    // RX bytes always sit in lane 0 regardless of the byte offset.
    assign w_off   = (r_state == S_RX_WAIT) ? 2'b00 : r_addr[1:0];
    assign w_rword = (r_state == S_RX_WAIT) ? {24'b0, rx_data} : bram_rdata;

    load_store_align u_align (
        .i_funct3 (r_funct3),
        .i_offset (w_off),
        .i_wdata  (r_wdata),
        .i_rword  (w_rword),
        .o_be     (w_be),
        .o_wdata  (w_wrep),
        .o_rdata  (w_rext)
    );

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) begin
                if (w_trap)         w_next = S_RESP;
                else if (w_is_data) w_next = we ? S_TX_WAIT : S_RX_WAIT;
                else if (w_is_stat) w_next = S_RESP;
                else if (w_is_bram) w_next = we ? S_BRAM_WR : S_BRAM_RD;
                else                w_next = S_RESP;
            end
            S_BRAM_WR: w_next = S_RESP;
            S_BRAM_RD: if (r_cnt == LAT) w_next = S_RESP;
            S_TX_WAIT: if (tx_ready) w_next = S_RESP;
            S_RX_WAIT: if (rx_valid) w_next = S_RESP;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        done     = (r_state == S_RESP);
        busy     = (r_state != S_IDLE);
        tx_valid = (r_state == S_TX_WAIT);
        rx_ready = (r_state == S_RX_WAIT) && rx_valid;
        bram_en  = 1'b0;
        bram_we  = '0;
        case (r_state)
            S_BRAM_WR: begin
                bram_en = 1'b1;
                bram_we = w_be;
            end
            S_BRAM_RD: bram_en = (r_cnt == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req) begin
                    r_addr   <= w_addr_al[BRAM_AW+1:0];
                    r_wdata  <= wdata;
                    r_funct3 <= funct3;
                    r_cnt    <= '0;
                    // Status and unmapped loads resolve immediately.
                    if (!w_trap && !we && !w_is_data) begin
                        if (w_is_stat)       r_rdata <= {30'b0, tx_ready, rx_valid};
                        else if (!w_is_bram) r_rdata <= '0;
                    end
                end
                S_BRAM_RD: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == LAT) r_rdata <= w_rext;
                end
                S_RX_WAIT: if (rx_valid) r_rdata <= w_rext;
                default: ;
            endcase
        end
    end

    assign rdata      = r_rdata;
    assign bram_addr  = r_addr[BRAM_AW+1:2];
    assign bram_wdata = w_wrep;
    assign tx_data    = r_wdata[7:0];

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural BRAM and
// directed UART handshakes.
module tb_mem_access_unit;

    localparam int unsigned BRAM_AW   = 15;
    localparam int unsigned RD_LAT    = 2;
    localparam logic [31:0] UART_BASE = 32'hFFFF_0000;

    logic               clk = 1'b0;
    logic               rstn, req, we;
    logic [2:0]         funct3;
    logic [31:0]        addr, wdata, rdata;
    logic               done, busy, err;
    logic               bram_en;
    logic [3:0]         bram_we;
    logic [BRAM_AW-1:0] bram_addr;
    logic [31:0]        bram_wdata, bram_rdata;
    logic               tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]         tx_data, rx_data;

    mem_access_unit #(
        .BRAM_AW   (BRAM_AW),
        .RD_LAT    (RD_LAT),
        .UART_BASE (UART_BASE)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .err(err), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_cnt = 0;
    int          rxr_cnt = 0;
    logic [3:0]  last_we = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] exp_rd = '0;

    logic [31:0] mem [0:(1<<BRAM_AW)-1];
    logic [31:0] pipe [RD_LAT];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            pipe[0] <= mem[bram_addr];
        end
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bram_rdata = pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bram_en) en_cnt++;
        if (rx_ready) rxr_cnt++;
        if (bram_en && bram_we != 4'b0000) begin
            last_we = bram_we;
            last_wd = bram_wdata;
        end
    end

    // Monitor: every done pops one expected response.
    always @(negedge clk) begin
        if (rstn === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no response at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_rdata"}, rdata, e.rdata);
                chk({e.name, "_err"}, {31'b0, err}, {31'b0, e.err});
                chk({e.name, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
                chk({e.name, "_busy"}, {31'b0, busy}, 32'd1);
            end
        end
    end

    task automatic expect_resp(input logic [31:0] er, input logic ee, input int lat, input string nm);
        exp_t e;
        e.rdata = er; e.err = ee; e.lat = lat; e.t0 = cyc; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        we = w; funct3 = f3; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 200 cycles", nm);
        end
        @(posedge clk); #1;
    endtask

    task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input int lat, input string nm);
        expect_resp(er, 1'b0, lat, nm);
        issue(w, f3, a, d);
        wait_done(nm);
    endtask

    initial begin
        int en0, rx0;
        for (int i = 0; i < (1 << BRAM_AW); i++) mem[i] = '0;
        rstn = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b010; addr = '0; wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ctl", {26'b0, done, busy, err, bram_en, tx_valid, rx_ready}, 32'h0);
        chk("rst_bram_we", {28'b0, bram_we}, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b1;

        op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, exp_rd, 2, "sw_10");
        chk("sw_10_we", {28'b0, last_we}, 32'hF);
        exp_rd = 32'hDEADBEEF;
        op(1'b0, 3'b010, 32'h10, 32'h0, exp_rd, 4, "lw_10");
        op(1'b1, 3'b000, 32'h13, 32'h80, exp_rd, 2, "sb_13");
        chk("sb_13_we", {28'b0, last_we}, 32'h8);
        chk("sb_13_wdata", last_wd, 32'h80808080);
        exp_rd = 32'hFFFFFF80;
        op(1'b0, 3'b000, 32'h13, 32'h0, exp_rd, 4, "lb_13");
        exp_rd = 32'h00000080;
        op(1'b0, 3'b100, 32'h13, 32'h0, exp_rd, 4, "lbu_13");
        exp_rd = 32'hFFFF80AD;
        op(1'b0, 3'b001, 32'h12, 32'h0, exp_rd, 4, "lh_12");
        exp_rd = 32'h0000BEEF;
        op(1'b0, 3'b101, 32'h10, 32'h0, exp_rd, 4, "lhu_10");
        op(1'b1, 3'b001, 32'h16, 32'h00001234, exp_rd, 2, "sh_16");
        chk("sh_16_we", {28'b0, last_we}, 32'hC);
        chk("sh_16_wdata", last_wd, 32'h12341234);
        exp_rd = 32'h12340000;
        op(1'b0, 3'b010, 32'h14, 32'h0, exp_rd, 4, "lw_14");

        en0 = en_cnt;
        exp_rd = 32'h0;
        op(1'b0, 3'b010, 32'h0002_0000, 32'h0, exp_rd, 1, "lw_unmapped");
        op(1'b1, 3'b010, 32'h0002_0000, 32'h5555AAAA, exp_rd, 1, "sw_unmapped");
        op(1'b1, 3'b010, UART_BASE + 32'h4, 32'h77, exp_rd, 1, "sw_status");
        chk("unmapped_no_bram", 32'(en_cnt - en0), 32'd0);

        expect_resp(exp_rd, 1'b0, 7, "tx");
        tx_ready = 1'b0;
        issue(1'b1, 3'b010, UART_BASE, 32'h00000041);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tx_hold", {22'b0, tx_valid, busy, tx_data}, {22'b0, 1'b1, 1'b1, 8'h41});
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_done("tx");
        tx_ready = 1'b0;

        rx0 = rxr_cnt;
        rx_valid = 1'b1;
        exp_rd = 32'h00000001;
        op(1'b0, 3'b010, UART_BASE + 32'h4, 32'h0, exp_rd, 1, "lw_status");
        chk("status_no_rx_ready", 32'(rxr_cnt - rx0), 32'd0);
        rx_valid = 1'b0;

        rx0 = rxr_cnt;
        exp_rd = 32'h0000007F;
        expect_resp(exp_rd, 1'b0, 5, "rx");
        issue(1'b0, 3'b010, UART_BASE, 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b1; rx_data = 8'h7F;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        wait_done("rx");
        chk("rx_ready_pulses", 32'(rxr_cnt - rx0), 32'd1);

        en0 = en_cnt;
`ifdef MEM_MISALIGN_TRAP_EN
        expect_resp(exp_rd, 1'b1, 1, "lw_12_mis");
        issue(1'b0, 3'b010, 32'h12, 32'h0);
        wait_done("lw_12_mis");
        chk("lw_12_mis_bram_en", 32'(en_cnt - en0), 32'd0);
`else
        exp_rd = 32'h80ADBEEF;
        expect_resp(exp_rd, 1'b0, 4, "lw_12_mis");
        issue(1'b0, 3'b010, 32'h12, 32'h0);
        wait_done("lw_12_mis");
        chk("lw_12_mis_bram_en", 32'(en_cnt - en0), 32'd1);
`endif

        // Reset while waiting on TX aborts without a response.
        tx_ready = 1'b0;
        issue(1'b1, 3'b010, UART_BASE, 32'h00000042);
        @(negedge clk);
        chk("abort_tx_valid_pre", {31'b0, tx_valid}, 32'd1);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("abort_ctl", {29'b0, tx_valid, busy, done}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data/instruction memory access stage downstream of the multicycle control FSM.
- Takes one load/store/fetch request per transaction from the datapath (address already selected by iord mux) and performs it against block RAM or memory-mapped UART.
- Returns sign/zero-extended read data plus a one-cycle done pulse; busy lets the control FSM hold its MEMREAD/MEMWRITE/FETCH state until completion.

Parameters:
- BRAM_AW, 15, BRAM word-address width (32-bit words).
- RD_LAT, 2, BRAM read latency in cycles (1..4).
- UART_BASE, 32'hFFFF_0000, MMIO base address.
  - UART_BASE+0: data.
  - UART_BASE+4: status.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- req  in  1  start transaction; sampled only in IDLE
- we  in  1  1 = store, 0 = load/fetch
- funct3  in  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- addr  in  32  byte address
- wdata  in  32  store data (low bytes used for sb/sh)
- rdata  out  32  extended load result; held until next done
- done  out  1  one-cycle completion pulse
- busy  out  1  high from accepted req until cycle after done
- err  out  1  misaligned-access pulse (see Optional Feature)
- bram_en  out  1  BRAM enable
- bram_we  out  4  byte write enables
- bram_addr  out  BRAM_AW  word address = addr[BRAM_AW+1:2]
- bram_wdata  out  32  lane-replicated store data
- bram_rdata  in  32  BRAM read data, valid RD_LAT cycles after bram_en
- tx_valid  out  1  UART TX byte valid
- tx_data  out  8  UART TX byte
- tx_ready  in  1  UART TX accepts byte
- rx_valid  in  1  UART RX byte available
- rx_data  in  8  UART RX byte
- rx_ready  out  1  consume RX byte

Behaviour:
- Reset (rstn=0 at posedge):
  - State goes to IDLE.
  - rdata=0; done=busy=err=0.
  - bram_en=0, bram_we=0.
  - tx_valid=0, rx_ready=0.
  - Reset mid-transaction aborts it: no done, and any pending tx_valid drops.
- States: IDLE, BRAM_RD, BRAM_WR, TX_WAIT, RX_WAIT, RESP.
- IDLE, req=1: latch addr/we/funct3/wdata, assert busy, then decode the address:
  - addr[31:2]==UART_BASE[31:2]+0:
    - Store goes to TX_WAIT: tx_valid=1, tx_data=wdata[7:0].
    - Load goes to RX_WAIT.
  - addr==UART_BASE+4, load: go to RESP with rdata={30'b0, tx_ready, rx_valid}.
    - Status stores are dropped and go to RESP.
  - addr < 4*2^BRAM_AW:
    - Store: bram_en=1 and bram_we from size/offset for one cycle, then RESP.
      - sb: 1 << addr[1:0].
      - sh: 4'b0011 << addr[1:0].
      - sw: 4'b1111.
      - bram_wdata replicates the byte/half across lanes.
    - Load: bram_en=1 for one cycle, then count RD_LAT cycles in BRAM_RD, then capture and extend.
  - Any other address: load returns 0, store is dropped, go to RESP.
- Load extension:
  - Select byte/half by addr[1:0] / addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - Unknown funct3 is treated as lw.
- TX_WAIT: hold tx_valid/tx_data until a cycle with tx_valid&&tx_ready, then RESP.
- RX_WAIT: wait for rx_valid.
  - rx_ready=1 for exactly the accepting cycle.
  - rdata is extended from rx_data per funct3 (lb sign-extends).
  - Then RESP.
- RESP: done=1 for one cycle, busy=1, then IDLE. busy is low in IDLE.
- Latency (req to done):
  - BRAM store: 2 cycles.
  - BRAM load: RD_LAT+2 cycles.
  - Status/unmapped: 1 cycle.
  - UART: unbounded.
- req asserted while busy is ignored. The control FSM holds req/inputs stable until done; inputs are latched anyway.
- Back-to-back: req may be high in the IDLE cycle right after RESP and is accepted.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: an lh/lhu/sh with addr[0]=1, or an lw/sw with addr[1:0]!=0, is rejected in IDLE.
  - No BRAM/UART activity; rdata is unchanged.
  - Go to RESP, where done=1 and err=1 in the same cycle.
- Undefined:
  - err is tied 0.
  - Offending low address bits are forced to 0, so the access aligns down (sh at 0x6 writes bytes 0x4-0x5).

Decomposition:
- Shared package core_pkg:
  - Funct3 size/sign constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - mem_state_t enum.
  - UART register offsets.
- One sub-module, load_store_align: combinational byte-enable generation, store lane replication, and load extraction/extension.
  - Reused later by a cache.

Test Plan:
- Reset, then sw addr=0x10 wdata=0xDEADBEEF, then lw addr=0x10 (RD_LAT=2):
  - done occurs 2 and 4 cycles after the respective req.
  - rdata=0xDEADBEEF.
- sb addr=0x13 wdata=0x80, then lb/lbu addr=0x13:
  - bram_we=4'b1000.
  - rdata=0xFFFFFF80 for lb, 0x00000080 for lbu.
- sw UART_BASE wdata=0x41 with tx_ready low for 5 cycles:
  - tx_valid=1, tx_data=0x41 held through the wait.
  - done comes 1 cycle after the handshake; busy is high throughout.
- lw UART_BASE+4 with rx_valid=1, tx_ready=0:
  - rdata=0x00000001, done after 1 cycle, no rx_ready.
- lw UART_BASE, rx_data=0x7F arriving after 3 cycles:
  - rx_ready pulses once; rdata=0x0000007F.
- lw addr=0x12:
  - With MEM_MISALIGN_TRAP_EN: err=done=1, bram_en never asserted.
  - Without it: reads word 0x10, err=0.
